// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
package tt_pkg;

  // Sequencer states: wait for start, walk the rows, announce completion.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } tt_state_e;

  // Number of truth-table rows for a given input count.
  function automatic int unsigned nrows(input int unsigned nin);
    return 32'd1 << nin;
  endfunction

  localparam int unsigned NIN_DEFAULT = 3;
  localparam int unsigned NROWS       = nrows(NIN_DEFAULT);

  // Truth table of F = (~x & z) | (x & ~y), bit i = row {x,y,z} == i.
  localparam logic [7:0] EXPECT_SOP = 8'h3A;

endpackage

// File: rtl/tt_settle_timer.sv
// Per-row settle timer: counts 0..SETTLE while enabled and flags the last cycle.
module tt_settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [W-1:0] Last = W'(SETTLE);

  logic [W-1:0] cnt_q;

  // Tick on the final hold cycle of a row; the sample is taken on that edge.
  assign tick_o = en_i && (cnt_q == Last);

  // Count while enabled, wrapping back to zero after each tick.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all input rows of a combinational block, captures F per row and
// flags rows where Fn fails to be the complement of F.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int unsigned NIN    = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [NIN-1:0]       xyz,
  input  logic                 f_in,
  input  logic                 fn_in,
  output logic [(1<<NIN)-1:0]  table_out,
  output logic [(1<<NIN)-1:0]  cmp_err,
  output logic                 err
);

  localparam int unsigned NRowsP  = nrows(NIN);
  localparam logic [NIN-1:0] LastRow = NIN'(NRowsP - 1);

  tt_state_e           state_q;
  logic [NIN-1:0]      row_q;
  logic                busy_q;
  logic                done_q;
  logic [NRowsP-1:0]   table_q;
  logic [NRowsP-1:0]   cmp_q;
  logic                err_q;

  logic                accept;
  logic                tick;
  logic                sample_eq;

  assign accept    = (state_q == StIdle) && start;
  // F equal to Fn means the complementary output is broken for this row.
  assign sample_eq = (f_in == fn_in);

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (state_q == StRun),
    .tick_o (tick)
  );

  // Sequencer FSM with row counter, capture registers and error reduction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      cmp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            row_q   <= '0;
            table_q <= '0;
            cmp_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        StRun: begin
          if (tick) begin
            table_q[row_q] <= f_in;
            cmp_q[row_q]   <= sample_eq;
            if (row_q == LastRow) begin
              // Terminal row ends the sweep; the row register parks at zero.
              state_q <= StFin;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= '0;
              err_q   <= (|cmp_q) | sample_eq;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          row_q   <= '0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign xyz       = row_q;
  assign table_out = table_q;
  assign cmp_err   = cmp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench for tt_sweep_capture with a behavioural SOP stand-in.
module tb_tt_sweep_capture;
  import tt_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start0;
  logic       busy, done, err, f, fn;
  logic [2:0] xyz;
  logic [7:0] table_out, cmp_err;
  logic       busy0, done0, err0, f0, fn0;
  logic [2:0] xyz0;
  logic [7:0] table0, cmp0;

  logic [7:0] tt, mask;
  int         mode;
  logic       d1, d2, e1, e2;

  int n_assert = 0;
  int n_fail   = 0;

  tt_sweep_capture #(.NIN(3), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .xyz(xyz),
    .f_in(f), .fn_in(fn), .table_out(table_out), .cmp_err(cmp_err), .err(err)
  );

  tt_sweep_capture #(.NIN(3), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .xyz(xyz0),
    .f_in(f0), .fn_in(fn0), .table_out(table0), .cmp_err(cmp0), .err(err0)
  );

  // Two-cycle delayed versions of the function for the settle-timing tests.
  always_ff @(posedge clk) begin
    d1 <= tt[xyz];
    d2 <= d1;
    e1 <= tt[xyz0];
    e2 <= e1;
  end

  // Stand-in SOP block: mode 0 combinational (mask selects rows with broken Fn,
  // X while idle), mode 2 two-cycle delayed.
  always_comb begin
    f  = 1'bx;
    fn = 1'bx;
    if (mode == 2) begin
      f  = d2;
      fn = ~d2;
    end else if (busy) begin
      f  = tt[xyz];
      fn = mask[xyz] ? tt[xyz] : ~tt[xyz];
    end
  end
  assign f0  = e2;
  assign fn0 = ~e2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Table captured when each row samples the value from two rows earlier.
  function automatic logic [7:0] lag2_table(input logic [7:0] t);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = t[(i >= 2) ? i - 2 : 0];
    return r;
  endfunction

  // One start pulse, row walk check, latency and result check.
  task automatic run_sweep(input string tag, input logic [7:0] exp_tab,
                           input logic [7:0] exp_cmp, input logic exp_err);
    int cyc;
    start = 1'b1;
    step();
    start  = 1'b0;
    start0 = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, busy, 1);
    while (!done && cyc < 60) begin
      chk({tag, "_xyz"}, xyz, (cyc - 1) / 3);
      step();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 8 * 3 + 1);
    chk({tag, "_busy_fin"}, busy, 0);
    chk({tag, "_xyz_fin"}, xyz, 0);
    chk({tag, "_table"}, table_out, exp_tab);
    chk({tag, "_cmp"}, cmp_err, exp_cmp);
    chk({tag, "_err"}, err, exp_err);
    step();
    chk({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    int cyc;
    int ndone;
    bit injected;
    int acc[$];
    int dn[$];
    logic pb;
    logic [7:0] gold;

    gold   = EXPECT_SOP;
    rst    = 1'b1;
    start  = 1'b1;
    start0 = 1'b1;
    mode   = 0;
    tt     = gold;
    mask   = 8'h00;
    step();
    step();
    start  = 1'b0;
    start0 = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xyz", xyz, 0);
    chk("rst_table", table_out, 0);
    chk("rst_cmp", cmp_err, 0);
    chk("rst_err", err, 0);
    chk("rst_table0", table0, 0);
    rst = 1'b0;
    step();
    step();
    chk("idle_busy", busy, 0);

    // Golden sweep and broken complement output.
    run_sweep("golden", gold, 8'h00, 1'b0);
    mask = 8'hFF;
    run_sweep("fn_eq_f", gold, 8'hFF, 1'b1);

    // Random functions with random broken-Fn rows.
    for (int k = 0; k < 4; k++) begin
      tt   = 8'($urandom);
      mask = 8'($urandom);
      run_sweep("rand", tt, mask, |mask);
    end

    // Delayed block: settled sampling vs no settle time.
    tt     = gold;
    mask   = 8'h00;
    mode   = 2;
    step();
    step();
    start0 = 1'b1;
    run_sweep("delay_s2", gold, 8'h00, 1'b0);
    chk("delay_s0_table", table0, lag2_table(gold));
    chk("delay_s0_differs", (table0 != gold), 1);
    chk("delay_s0_err", err0, 0);
    chk("delay_s0_idle", busy0, 0);
    mode = 0;

    // Start during RUN at row 4 and during FIN is ignored.
    tt = 8'h5C;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    ndone = 0;
    injected = 1'b0;
    while (!done && cyc < 60) begin
      start = (xyz == 3'd4 && !injected);
      if (xyz == 3'd4) injected = 1'b1;
      step();
      cyc++;
    end
    chk("ign_lat", cyc, 25);
    chk("ign_table", table_out, 8'h5C);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_fin_busy", busy, 0);
    chk("ign_fin_done", done, 0);
    step();
    chk("ign_fin_busy2", busy, 0);
    chk("ign_fin_table", table_out, 8'h5C);

    // Reset at row 5 aborts the sweep; reset beats start.
    tt = gold;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40 && xyz != 3'd5; c++) step();
    chk("abort_row5", xyz, 5);
    rst   = 1'b1;
    start = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_xyz", xyz, 0);
    chk("abort_table", table_out, 0);
    chk("abort_cmp", cmp_err, 0);
    chk("abort_done", done, 0);
    step();
    chk("rst_beats_start", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_sweep("after_abort", gold, 8'h00, 1'b0);

    // Start held high: back-to-back sweeps, table cleared on each accept.
    start = 1'b1;
    pb = busy;
    for (int c = 0; c < 120 && dn.size() < 3; c++) begin
      step();
      if (busy && !pb) begin
        acc.push_back(c);
        chk("b2b_clear", table_out, 0);
      end
      if (done) dn.push_back(c);
      pb = busy;
    end
    start = 1'b0;
    chk("b2b_ndone", dn.size(), 3);
    chk("b2b_nacc", acc.size(), 3);
    for (int i = 1; i < dn.size(); i++) chk("b2b_done_period", dn[i] - dn[i-1], 26);
    for (int i = 1; i < acc.size(); i++) chk("b2b_acc_period", acc[i] - acc[i-1], 26);
    for (int i = 0; i + 1 < acc.size() && i < dn.size(); i++)
      chk("b2b_gap", acc[i+1] - dn[i], 2);
    step();
    step();
    chk("b2b_idle", busy, 0);
    chk("b2b_table", table_out, gold);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
